// File: rtl/video_tx_pkg.sv
// Shared types and constants for the video test-pattern transmitter.
// Pattern/FSM enums and the colour-bar table ({R,G,B} bit per bar).
package video_tx_pkg;

  typedef enum logic [1:0] {
    BARS  = 2'd0,
    RAMP  = 2'd1,
    CHECK = 2'd2,
    SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Element i is bar i, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/tpg_pattern.sv
// Combinational test-pattern colour for the pixel at (hcnt, vcnt).
// In: hcnt, vcnt, pat_q. Out: red_o, green_o, blue_o (unblanked).
module tpg_pattern
  import video_tx_pkg::*;
#(
  parameter int CD = 8,
  parameter int HA = 1280,
  parameter int HW = 11,
  parameter int VW = 10
) (
  input  logic [HW-1:0] hcnt,
  input  logic [VW-1:0] vcnt,
  input  pattern_e      pat_q,
  output logic [CD-1:0] red_o,
  output logic [CD-1:0] green_o,
  output logic [CD-1:0] blue_o
);

  localparam int BAR_W = HA / 8;
  localparam logic [HW-1:0] BAR_WV = HW'(BAR_W);
  localparam logic [VW-1:0] V_B4 = VW'(16);
  localparam logic [CD-1:0] MID = {1'b1, {(CD-1){1'b0}}};

  logic [2:0] bar_idx;
  logic [2:0] bar;
  logic       chk;

  assign bar_idx = 3'(hcnt / BAR_WV);
  assign bar     = BAR_RGB[bar_idx];
  assign chk     = hcnt[4] ^ (|(vcnt & V_B4));

  always_comb begin
    red_o   = '0;
    green_o = '0;
    blue_o  = '0;
    unique case (1'b1)
      (pat_q == BARS): begin
        red_o   = {CD{bar[2]}};
        green_o = {CD{bar[1]}};
        blue_o  = {CD{bar[0]}};
      end
      (pat_q == RAMP): begin
        red_o   = hcnt[CD-1:0];
        green_o = hcnt[CD-1:0];
        blue_o  = hcnt[CD-1:0];
      end
      (pat_q == CHECK): begin
        red_o   = {CD{chk}};
        green_o = {CD{chk}};
        blue_o  = {CD{chk}};
      end
      (pat_q == SOLID): begin
        red_o   = MID;
        green_o = MID;
        blue_o  = MID;
      end
    endcase
  end

endmodule

// File: rtl/video_tx_gen.sv
// Raster timing + test-pattern source; starts/stops on frame bounds.
// In: clk, rst, en_i, pattern_i. Out: RGB, dv/hs/vs, frame/line pulses.
module video_tx_gen
  import video_tx_pkg::*;
#(
  parameter int COLORDEPTH = 8,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  output logic [COLORDEPTH-1:0] red_o,
  output logic [COLORDEPTH-1:0] green_o,
  output logic [COLORDEPTH-1:0] blue_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  frame_start_o,
  output logic                  line_end_o
);

  localparam int CD = COLORDEPTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Wide enough for the ramp slice and the checker bit 4.
  localparam int HC0 = $clog2(H_TOTAL);
  localparam int HWA = (HC0 > CD) ? HC0 : CD;
  localparam int HW  = (HWA > 5) ? HWA : 5;
  localparam int VC0 = $clog2(V_TOTAL);
  localparam int VW  = (VC0 > 5) ? VC0 : 5;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LE   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            stop_pend_q, stop_pend_d;
  pattern_e        pat_q, pat_d;

  logic [CD-1:0]   red_q, red_d;
  logic [CD-1:0]   green_q, green_d;
  logic [CD-1:0]   blue_q, blue_d;
  logic            dv_q, dv_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fs_q, fs_d;
  logic            le_q, le_d;

  logic [CD-1:0]   tpg_r, tpg_g, tpg_b;
  logic            h_last, f_last, run, act;

  tpg_pattern #(
    .CD (CD),
    .HA (H_ACTIVE),
    .HW (HW),
    .VW (VW)
  ) u_tpg (
    .hcnt    (hcnt_q),
    .vcnt    (vcnt_q),
    .pat_q   (pat_q),
    .red_o   (tpg_r),
    .green_o (tpg_g),
    .blue_o  (tpg_b)
  );

  assign h_last = (hcnt_q == H_LAST);
  assign f_last = h_last && (vcnt_q == V_LAST);

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    stop_pend_d = stop_pend_q;
    pat_d       = pat_q;
    unique case (state_q)
      IDLE: begin
        hcnt_d      = '0;
        vcnt_d      = '0;
        stop_pend_d = 1'b0;
        if (en_i) begin
          state_d = RUN;
          pat_d   = pattern_e'(pattern_i);
        end
      end
      RUN: begin
        // Tracks the latest en_i; only honoured at the frame wrap.
        stop_pend_d = !en_i;
        hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
        if (h_last) begin
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
        if (f_last) begin
          pat_d = pattern_e'(pattern_i);
          if (stop_pend_q) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    run     = (state_q == RUN);
    act     = run && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    dv_d    = act;
    hs_d    = run && (hcnt_q >= H_SS) && (hcnt_q < H_SE);
    vs_d    = run && (vcnt_q >= V_SS) && (vcnt_q < V_SE);
    fs_d    = act && (hcnt_q == '0) && (vcnt_q == '0);
    le_d    = act && (hcnt_q == H_LE);
    red_d   = act ? tpg_r : '0;
    green_d = act ? tpg_g : '0;
    blue_d  = act ? tpg_b : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      pat_q       <= BARS;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      dv_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      fs_q        <= 1'b0;
      le_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      stop_pend_q <= stop_pend_d;
      pat_q       <= pat_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      dv_q        <= dv_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      le_q        <= le_d;
    end
  end

  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign dv_o          = dv_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign frame_start_o = fs_q;
  assign line_end_o    = le_q;

endmodule

// File: doc/video_tx_gen.md
# video_tx_gen

- Video source and timing transmitter: drives the same RGB + `dv`/`hs`/`vs` pixel interface that the grayscale/blur pipeline consumes.
- Generates one progressive raster of parameterised geometry with a selectable test pattern.
- Sits at the front of the chain in simulation and FPGA bring-up, standing in for the camera/HDMI receiver.
- Starts and stops only on frame boundaries, so downstream line buffers always see whole frames.

## Interface
- `COLORDEPTH`, 8: bits per colour channel
- `H_ACTIVE`, 1280: active pixels per line; must be a multiple of 8
- `H_FP`, 110: horizontal front porch, in cycles
- `H_SYNC`, 40: horizontal sync width, in cycles
- `H_BP`, 220: horizontal back porch, in cycles
- `V_ACTIVE`, 720: active lines
- `V_FP`, 5: vertical front porch, in lines
- `V_SYNC`, 5: vertical sync width, in lines
- `V_BP`, 20: vertical back porch, in lines
- `clk`  in  1  pixel clock; the single clock
- `rst`  in  1  synchronous, active-high reset
- `en_i`  in  1  run request; level-sensitive
- `pattern_i`  in  2  pattern select: 0 colour bars, 1 gray ramp, 2 checkerboard, 3 solid gray
- `red_o`, `green_o`, `blue_o`  out  COLORDEPTH each  pixel data; zero whenever `dv_o`=0
- `dv_o`  out  1  active pixel
- `hs_o`  out  1  horizontal sync, active-high
- `vs_o`  out  1  vertical sync, active-high
- `frame_start_o`  out  1  pulse on the first active pixel of a frame
- `line_end_o`  out  1  pulse on the last active pixel of each line

## Operation
- Counters: `hcnt` runs 0..H_TOTAL-1 and `vcnt` runs 0..V_TOTAL-1, where H_TOTAL = sum of the H parameters and V_TOTAL = sum of the V parameters.
  - `hcnt` wraps to 0 and increments `vcnt`.
  - `vcnt` wraps to 0 at V_TOTAL-1.
- Line order is active, front porch, sync, back porch; frame order is the same in lines.
- `dv` = (`hcnt` < H_ACTIVE) and (`vcnt` < V_ACTIVE).
- `hs` = `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- `vs` = `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). `vs` changes only when `hcnt` = 0.
- Syncs toggle during blanking lines as well.
- State machine (states IDLE, RUN):
  - IDLE: counters held at 0; all outputs 0. `en_i`=1 → RUN.
  - RUN: counters advance every cycle.
  - When `en_i` is sampled 0 during RUN, a `stop_pend` flag is set. At the wrap `hcnt`=H_TOTAL-1, `vcnt`=V_TOTAL-1 with `stop_pend` set, go to IDLE and clear `stop_pend`.
  - If `en_i` returns to 1 before the wrap, `stop_pend` clears and the frame sequence continues with no gap.
- `pattern_i` is latched into `pat_q` at the cycle RUN is entered and at every frame wrap. A mid-frame change takes effect on the next frame.
- Patterns (FS = all-ones at COLORDEPTH, `x`=`hcnt`, `y`=`vcnt`):
  - Colour bars: bar index = `x` / (H_ACTIVE/8). Bars in order: white, yellow, cyan, green, magenta, red, blue, black; each channel is FS or 0.
  - Gray ramp: R=G=B = `x`[COLORDEPTH-1:0], wrapping.
  - Checkerboard: `x`[4] ^ `y`[4] gives FS, otherwise 0, on all channels.
  - Solid: R=G=B = MSB only set (0x80 at 8 bits).
- `rst` mid-frame: next cycle is IDLE, counters 0, `stop_pend` 0, all outputs 0. No partial-frame completion.

## Timing
- All outputs are registered, one cycle behind the counter state that produces them. Every output resets to 0.
- `en_i`=1 sampled in IDLE at edge N:
  - RUN with counters 0 from N+1.
  - First `dv_o`=1 together with `frame_start_o`=1 at N+2.
- `frame_start_o` is high for exactly one cycle per frame, coincident with pixel (0,0).
- `line_end_o` is coincident with `dv_o` at `x`=H_ACTIVE-1. It asserts V_ACTIVE times per frame and never in vertical blanking.
- Sustained throughput: one pixel per clock during active video. Frame period = H_TOTAL·V_TOTAL cycles exactly.
- After a stop, the last output cycle is the final back-porch cycle. All outputs are 0 from the following cycle.

## Structure
- `video_tx_pkg`:
  - `pattern_e` typedef (BARS, RAMP, CHECK, SOLID)
  - `state_e` typedef (IDLE, RUN)
  - 8-entry bar colour constant table (3 bits, one per channel)
- Sub-module `tpg_pattern`: combinational; inputs `hcnt`, `vcnt`, `pat_q`; outputs RGB.
- Top block holds the counters, FSM, sync decode and output registers.

## Test plan
Small geometry for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL 24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL 8); COLORDEPTH=8.
- Reset and idle: `rst` held 5 cycles, then `en_i`=0 for 50 cycles → every output is 0 throughout.
- Start latency and geometry: `en_i`=1 sampled at edge N →
  - `dv_o` and `frame_start_o` high at N+2;
  - 16 `dv_o` cycles per line, `hs_o` high for 3 cycles starting 18 cycles after each line start;
  - `vs_o` high for 48 cycles; `frame_start_o` repeats every 192 cycles.
- Colour bars: `pattern_i`=0 → pixels 0–1 are FF/FF/FF, pixels 2–3 are FF/FF/00, …, pixels 14–15 are 00/00/00. `line_end_o` fires on pixel 15 only.
- Pattern latch: switch `pattern_i` from 1 to 3 mid-frame →
  - the current frame stays a ramp, with pixel x = x;
  - the next frame is all 0x80;
  - RGB is 0 in blanking.
- Stop at frame boundary: drop `en_i` at cycle 60 of a frame → the frame completes all 192 cycles, then all outputs are 0. Re-assert `en_i` → `frame_start_o` appears 2 cycles later.
- Reset mid-frame: `rst` at cycle 100 of a frame → all outputs are 0 the next cycle. With `en_i`=1 held, a fresh frame starts 2 cycles after `rst` deasserts.
